draw_tile_blitter: RTL
======================

Name: draw_tile_blitter

Overview:
- Parametrised tile blitter for the VGA draw path.
- On a start pulse it reads one TILE_W x TILE_H tile from an external synchronous ROM holding NUM_TILES tiles, and streams pixel writes (x, y, colour, plot) to the VGA adapter at grid cell (grid_x, grid_y).
- Over the fixed 20x20 square drawer it adds:
  - a start/busy/done handshake,
  - a tile-select input,
  - configurable ROM latency,
  - transparent-colour skipping,
  - screen-edge clipping.

Parameters:
TILE_W, 20, tile width in pixels (also grid pitch in x)
TILE_H, 20, tile height in pixels (also grid pitch in y)
NUM_TILES, 4, tiles stored back-to-back in ROM
COLOUR_W, 9, colour word width
X_W, 8, screen x width
Y_W, 7, screen y width
GRID_W, 4, grid coordinate width
SCREEN_W, 160, pixels with x >= SCREEN_W are clipped
SCREEN_H, 120, pixels with y >= SCREEN_H are clipped
ROM_LAT, 1, ROM read latency in cycles (1..3)
TRANSP_EN, 1, enable transparent-pixel skipping
TRANSP_COLOUR, 9'h1FF, colour that is not plotted when TRANSP_EN=1
ADDR_W, 11, ROM address width; must satisfy 2^ADDR_W >= NUM_TILES*TILE_W*TILE_H

Ports:
clk  in  1  clock
resetn  in  1  synchronous reset, active-low
start  in  1  request one tile draw; sampled only in IDLE
grid_x  in  GRID_W  grid column; captured on accepted start
grid_y  in  GRID_W  grid row; captured on accepted start
tile_sel  in  clog2(NUM_TILES)  tile index; captured on accepted start
rom_addr  out  ADDR_W  ROM read address
rom_q  in  COLOUR_W  ROM data, valid ROM_LAT cycles after rom_addr
x  out  X_W  pixel x to VGA
y  out  Y_W  pixel y to VGA
colour  out  COLOUR_W  pixel colour to VGA
plot  out  1  write strobe for x/y/colour
busy  out  1  high from accept until the last pixel is issued
done  out  1  one-cycle pulse after the last pixel

Behaviour:
- Reset (resetn low at a clk edge) forces:
  - state IDLE; all counters and pipeline valids 0;
  - x=0, y=0, plot=0, busy=0, done=0, rom_addr=0.
  - Reset mid-draw aborts immediately: no further plot and no done pulse.
- States:
  - IDLE: on start=1, capture grid_x, grid_y, tile_sel; px=py=0; go to FETCH.
  - FETCH:
    - rom_addr = tile_sel*TILE_W*TILE_H + py*TILE_W + px.
    - px increments each cycle; at px=TILE_W-1, px wraps to 0 and py increments.
    - After the address for (TILE_W-1, TILE_H-1), go to DRAIN.
  - DRAIN: wait ROM_LAT cycles until the pipeline is empty, then go to FIN.
  - FIN: done=1 for exactly one cycle, busy=0, return to IDLE. start is also accepted in this cycle.
- busy is 1 in FETCH and DRAIN. start while busy is ignored and does not corrupt the captured inputs.
- Pipeline:
  - (px, py, valid) is delayed ROM_LAT cycles to align with rom_q.
  - colour = rom_q, combinational.
  - x = grid_x*TILE_W + px and y = grid_y*TILE_H + py, computed at full width then truncated to X_W/Y_W.
- plot = aligned valid AND (not TRANSP_EN OR rom_q != TRANSP_COLOUR) AND x_full < SCREEN_W AND y_full < SCREEN_H.
  - Clipping uses the untruncated sums.
  - Suppressed pixels still consume their cycle.
- Timing: accepting start at edge E0 gives:
  - address of pixel k presented in cycle k+1;
  - plot for pixel k in cycle k+1+ROM_LAT;
  - done in cycle TILE_W*TILE_H+ROM_LAT+1.
  - Draw length is fixed, independent of transparency or clipping.
- Pixel order: raster (x fastest), one pixel per cycle, no stalls.

Test Plan:
- Defaults; reset; start with grid (0,0), tile 0, ROM word = address:
  - 400 plots in cycles 2..401;
  - first x=0 y=0 colour=0; last x=19 y=19 colour=399;
  - done=1 in cycle 402 only; busy high in cycles 1..401.
- tile_sel=2, grid (7,5): first rom_addr=800; x spans 140..159, y spans 100..119; 400 plots.
- grid (8,0): x_full 160..179, all clipped → plot never high; done still in cycle 402.
- TRANSP_EN=1, ROM words 0x1FF at even addresses: plot high only for odd-address pixels (200 plots); done timing unchanged.
- start pulsed again in cycle 100 of a draw: ignored, output identical to a single draw. start held high through FIN: second draw begins, first rom_addr in cycle 403.
- resetn low in cycle 150: from the next cycle plot=0, busy=0, no done. A new start after reset draws a full 400-pixel tile.
- ROM_LAT=3 build: first plot in cycle 4; done in cycle 404.

Source files
------------

// File: rtl/draw_tile_blitter.sv
// Tile blitter: fetches one TILE_W x TILE_H tile from a synchronous ROM and
// streams clipped, optionally transparent-skipped pixel writes to the VGA adapter.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | issuing one ROM address per cycle in raster order
// DRAIN | waiting ROM_LAT cycles for the last words to return
// FIN   | one-cycle done pulse; start accepted here as well
module draw_tile_blitter #(
  parameter int TILE_W    = 20,
  parameter int TILE_H    = 20,
  parameter int NUM_TILES = 4,
  parameter int COLOUR_W  = 9,
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int GRID_W    = 4,
  parameter int SCREEN_W  = 160,
  parameter int SCREEN_H  = 120,
  parameter int ROM_LAT   = 1,
  parameter int TRANSP_EN = 1,
  parameter logic [COLOUR_W-1:0] TRANSP_COLOUR = 9'h1FF,
  parameter int ADDR_W    = 11,
  localparam int TS_W     = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [GRID_W-1:0]   grid_x,
  input  logic [GRID_W-1:0]   grid_y,
  input  logic [TS_W-1:0]     tile_sel,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_q,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam int PX_W     = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int PY_W     = (TILE_H > 1) ? $clog2(TILE_H) : 1;
  localparam int TILE_PIX = TILE_W * TILE_H;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t state_q, state_d;

  logic [GRID_W-1:0] gx_q, gy_q;
  logic [TS_W-1:0]   ts_q;
  logic [PX_W-1:0]   px_q;
  logic [PY_W-1:0]   py_q;
  logic [1:0]        drain_q;
  logic              accept;
  logic              last_pix;

  logic              v_pipe  [ROM_LAT];
  logic [PX_W-1:0]   px_pipe [ROM_LAT];
  logic [PY_W-1:0]   py_pipe [ROM_LAT];

  logic [31:0]       x_full, y_full;

  assign last_pix = (px_q == PX_W'(TILE_W - 1)) && (py_q == PY_W'(TILE_H - 1));

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        busy = 1'b1;
        if (last_pix) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_q == 2'd0) state_d = S_FIN;
      end
      S_FIN: begin
        done = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      gx_q    <= '0;
      gy_q    <= '0;
      ts_q    <= '0;
      px_q    <= '0;
      py_q    <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        gx_q <= grid_x;
        gy_q <= grid_y;
        ts_q <= tile_sel;
        px_q <= '0;
        py_q <= '0;
      end else if (state_q == S_FETCH) begin
        if (px_q == PX_W'(TILE_W - 1)) begin
          px_q <= '0;
          py_q <= last_pix ? '0 : py_q + 1'b1;
        end else begin
          px_q <= px_q + 1'b1;
        end
      end
      // Drain down-counter is loaded as the last address leaves FETCH.
      if (state_q == S_FETCH && last_pix) begin
        drain_q <= 2'(ROM_LAT - 1);
      end else if (state_q == S_DRAIN && drain_q != 2'd0) begin
        drain_q <= drain_q - 2'd1;
      end
    end
  end

  assign rom_addr = ADDR_W'(32'(ts_q) * TILE_PIX + 32'(py_q) * TILE_W + 32'(px_q));

  // Pixel coordinates ride alongside the ROM so they line up with rom_q.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        v_pipe[i]  <= 1'b0;
        px_pipe[i] <= '0;
        py_pipe[i] <= '0;
      end
    end else begin
      v_pipe[0]  <= (state_q == S_FETCH);
      px_pipe[0] <= px_q;
      py_pipe[0] <= py_q;
      for (int i = 1; i < ROM_LAT; i++) begin
        v_pipe[i]  <= v_pipe[i-1];
        px_pipe[i] <= px_pipe[i-1];
        py_pipe[i] <= py_pipe[i-1];
      end
    end
  end

  assign x_full = 32'(gx_q) * TILE_W + 32'(px_pipe[ROM_LAT-1]);
  assign y_full = 32'(gy_q) * TILE_H + 32'(py_pipe[ROM_LAT-1]);
  assign x      = X_W'(x_full);
  assign y      = Y_W'(y_full);
  assign colour = rom_q;

  assign plot = v_pipe[ROM_LAT-1]
              && ((TRANSP_EN == 0) || (rom_q != TRANSP_COLOUR))
              && (x_full < 32'(SCREEN_W))
              && (y_full < 32'(SCREEN_H));

endmodule
